// File: rtl/vga_fb_ctrl_pkg.sv
// Shared timing defaults, counter/address widths and the pixel-pipeline control word.
// Imported by the VGA timing generator and the framebuffer scan-out top.
package vga_fb_ctrl_pkg;

    localparam int DEF_CLK_DIV     = 4;
    localparam int DEF_H_ACTIVE    = 640;
    localparam int DEF_H_FP        = 16;
    localparam int DEF_H_SYNC      = 96;
    localparam int DEF_H_BP        = 48;
    localparam int DEF_V_ACTIVE    = 480;
    localparam int DEF_V_FP        = 10;
    localparam int DEF_V_SYNC      = 2;
    localparam int DEF_V_BP        = 33;
    localparam int DEF_SCALE_SHIFT = 3;

    localparam int DIV_W = 8;
    localparam int CNT_W = 12;
    localparam int FB_AW = 13;

    // Control bits that travel alongside a pixel from its tick to the pins.
    typedef struct packed {
        logic vld;
        logic en;
        logic hs;
        logic vs;
    } pix_ctl_t;

    localparam pix_ctl_t PIX_CTL_RST = '{vld: 1'b0, en: 1'b0, hs: 1'b1, vs: 1'b1};

endpackage

// File: rtl/vga_fb_ctrl_timing.sv
// Pixel-enable divider plus h/v raster counters; raw sync/active flags are combinational
// on the counters, frame_start fires on the tick at (0, V_ACTIVE). No backpressure.
module vga_timing
    import vga_fb_ctrl_pkg::*;
#(
    parameter int CLK_DIV  = DEF_CLK_DIV,
    parameter int H_ACTIVE = DEF_H_ACTIVE,
    parameter int H_FP     = DEF_H_FP,
    parameter int H_SYNC   = DEF_H_SYNC,
    parameter int H_BP     = DEF_H_BP,
    parameter int V_ACTIVE = DEF_V_ACTIVE,
    parameter int V_FP     = DEF_V_FP,
    parameter int V_SYNC   = DEF_V_SYNC,
    parameter int V_BP     = DEF_V_BP
) (
    input  logic             sys_clk,
    input  logic             sys_rst,
    output logic             tick,
    output logic [CNT_W-1:0] h,
    output logic [CNT_W-1:0] v,
    output logic             active,
    output logic             hsync_raw,
    output logic             vsync_raw,
    output logic             frame_start
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0] H_MAX   = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_MAX   = CNT_W'(V_TOTAL - 1);
    localparam logic [CNT_W-1:0] H_ACT   = CNT_W'(H_ACTIVE);
    localparam logic [CNT_W-1:0] V_ACT   = CNT_W'(V_ACTIVE);
    localparam logic [CNT_W-1:0] HS_BEG  = CNT_W'(H_ACTIVE + H_FP);
    localparam logic [CNT_W-1:0] HS_END  = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [CNT_W-1:0] VS_BEG  = CNT_W'(V_ACTIVE + V_FP);
    localparam logic [CNT_W-1:0] VS_END  = CNT_W'(V_ACTIVE + V_FP + V_SYNC);

    logic [DIV_W-1:0] div;

    assign tick = (div == DIV_MAX);

    always_ff @(posedge sys_clk or negedge sys_rst) begin
        if (!sys_rst) begin
            div <= '0;
            h   <= '0;
            v   <= '0;
        end else begin
            div <= tick ? '0 : div + 1'b1;
            if (tick) begin
                if (h == H_MAX) begin
                    h <= '0;
                    v <= (v == V_MAX) ? '0 : v + 1'b1;
                end else begin
                    h <= h + 1'b1;
                end
            end
        end
    end

    assign active      = (h < H_ACT) && (v < V_ACT);
    assign hsync_raw   = !((h >= HS_BEG) && (h < HS_END));
    assign vsync_raw   = !((v >= VS_BEG) && (v < VS_END));
    assign frame_start = tick && (h == '0) && (v == V_ACT);

endmodule

// File: rtl/vga_fb_ctrl.sv
// VGA scan-out: fetches upscaled RGB332 framebuffer bytes and drives the pins.
// Latency 3 sys_clk from pixel tick to pins (tick -> fb_rd -> fb_data valid -> pins); no backpressure.
module vga_fb_ctrl
    import vga_fb_ctrl_pkg::*;
#(
    parameter int CLK_DIV     = DEF_CLK_DIV,
    parameter int H_ACTIVE    = DEF_H_ACTIVE,
    parameter int H_FP        = DEF_H_FP,
    parameter int H_SYNC      = DEF_H_SYNC,
    parameter int H_BP        = DEF_H_BP,
    parameter int V_ACTIVE    = DEF_V_ACTIVE,
    parameter int V_FP        = DEF_V_FP,
    parameter int V_SYNC      = DEF_V_SYNC,
    parameter int V_BP        = DEF_V_BP,
    parameter int SCALE_SHIFT = DEF_SCALE_SHIFT
) (
    input  logic             sys_clk,
    input  logic             sys_rst,
    input  logic             enable,
    output logic             fb_rd,
    output logic [FB_AW-1:0] fb_addr,
    input  logic [7:0]       fb_data,
    output logic [2:0]       vga_red,
    output logic [2:0]       vga_grn,
    output logic [1:0]       vga_blu,
    output logic             vga_hsync,
    output logic             vga_vsync,
    output logic             frame_start
);

    localparam int               FB_W   = H_ACTIVE >> SCALE_SHIFT;
    localparam logic [FB_AW-1:0] FB_W_A = FB_AW'(FB_W);

    logic             tick;
    logic [CNT_W-1:0] h;
    logic [CNT_W-1:0] v;
    logic             active;
    logic             hsync_raw;
    logic             vsync_raw;

    vga_timing #(
        .CLK_DIV  (CLK_DIV),
        .H_ACTIVE (H_ACTIVE),
        .H_FP     (H_FP),
        .H_SYNC   (H_SYNC),
        .H_BP     (H_BP),
        .V_ACTIVE (V_ACTIVE),
        .V_FP     (V_FP),
        .V_SYNC   (V_SYNC),
        .V_BP     (V_BP)
    ) u_timing (
        .sys_clk     (sys_clk),
        .sys_rst     (sys_rst),
        .tick        (tick),
        .h           (h),
        .v           (v),
        .active      (active),
        .hsync_raw   (hsync_raw),
        .vsync_raw   (vsync_raw),
        .frame_start (frame_start)
    );

    logic             fetch;
    logic [FB_AW-1:0] fb_row;
    logic [FB_AW-1:0] fb_col;
    logic [FB_AW-1:0] addr_nxt;
    pix_ctl_t         s1;
    pix_ctl_t         s2;

    assign fetch    = tick && active && enable;
    assign fb_row   = FB_AW'(v >> SCALE_SHIFT);
    assign fb_col   = FB_AW'(h >> SCALE_SHIFT);
    assign addr_nxt = fb_row * FB_W_A + fb_col;

    // s1 covers the fb_rd cycle, s2 the cycle fb_data is valid; pins load on the edge after s2.
    always_ff @(posedge sys_clk or negedge sys_rst) begin
        if (!sys_rst) begin
            fb_rd                       <= 1'b0;
            fb_addr                     <= '0;
            s1                          <= PIX_CTL_RST;
            s2                          <= PIX_CTL_RST;
            {vga_red, vga_grn, vga_blu} <= '0;
            vga_hsync                   <= 1'b1;
            vga_vsync                   <= 1'b1;
        end else begin
            fb_rd <= fetch;
            if (fetch) begin
                fb_addr <= addr_nxt;
            end
            s1 <= '{vld: tick, en: fetch, hs: hsync_raw, vs: vsync_raw};
            s2 <= s1;
            if (s2.vld) begin
                {vga_red, vga_grn, vga_blu} <= s2.en ? fb_data : 8'h00;
                vga_hsync                   <= s2.hs;
                vga_vsync                   <= s2.vs;
            end
        end
    end

endmodule

// File: tb/tb_vga_fb_ctrl.sv
// Bench for vga_fb_ctrl on a reduced raster: directed vector table, random enable
// traffic against a raster-position reference model, and reset corner sequences.
module tb_vga_fb_ctrl;

    localparam int D     = 2;
    localparam int HA    = 128;
    localparam int HT    = 160;
    localparam int HS0   = 136;
    localparam int HS1   = 152;
    localparam int VA    = 32;
    localparam int VT    = 40;
    localparam int VS0   = 34;
    localparam int VS1   = 37;
    localparam int S     = 1;
    localparam int FBW   = 64;
    localparam int LOG_N = 32768;
    localparam int NV    = 12;

    logic        sys_clk = 1'b0;
    logic        sys_rst;
    logic        enable;
    logic        fb_rd;
    logic [12:0] fb_addr;
    logic [7:0]  fb_data = 8'h00;
    logic [2:0]  vga_red;
    logic [2:0]  vga_grn;
    logic [1:0]  vga_blu;
    logic        vga_hsync;
    logic        vga_vsync;
    logic        frame_start;

    vga_fb_ctrl #(
        .CLK_DIV(D), .H_ACTIVE(HA), .H_FP(8), .H_SYNC(16), .H_BP(8),
        .V_ACTIVE(VA), .V_FP(2), .V_SYNC(3), .V_BP(3), .SCALE_SHIFT(S)
    ) dut (
        .sys_clk     (sys_clk),
        .sys_rst     (sys_rst),
        .enable      (enable),
        .fb_rd       (fb_rd),
        .fb_addr     (fb_addr),
        .fb_data     (fb_data),
        .vga_red     (vga_red),
        .vga_grn     (vga_grn),
        .vga_blu     (vga_blu),
        .vga_hsync   (vga_hsync),
        .vga_vsync   (vga_vsync),
        .frame_start (frame_start)
    );

    always #5 sys_clk = ~sys_clk;

    logic [7:0] mem [0:1023];
    bit         en_log [0:LOG_N-1];
    int         edges = 0;
    int         n_cmp = 0;
    int         n_fail = 0;
    logic [12:0] exp_addr = '0;

    typedef struct {
        int         h;
        int         v;
        bit         en;
        logic [7:0] px;
        logic [12:0] addr;
        bit         rd;
        bit         fs;
        logic [2:0] r;
        logic [2:0] g;
        logic [1:0] b;
        bit         hs;
        bit         vs;
    } vec_t;

    vec_t vec [NV];

    // Synchronous framebuffer: data appears the cycle after fb_rd.
    initial begin
        forever begin
            @(posedge sys_clk);
            if (fb_rd === 1'b1) fb_data <= mem[fb_addr];
        end
    end

    // Rising edges since reset release, and the enable value seen at each.
    initial begin
        forever begin
            @(posedge sys_clk or negedge sys_rst);
            if (!sys_rst) begin
                edges = 0;
            end else begin
                edges = edges + 1;
                if (edges < LOG_N) en_log[edges] = enable;
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (edge %0d)", name, act, exp, edges);
        end
    endtask

    function automatic int addr_of(input int h, input int v);
        return (v >> S) * FBW + (h >> S);
    endfunction

    function automatic bit in_active(input int h, input int v);
        return (h < HA) && (v < VA);
    endfunction

    // Pixel n's tick ends at edge (n+1)*D; its pins appear after edge (n+1)*D+2.
    task automatic bg_check();
        int m, n, h, v, t;
        logic [7:0] rgb;
        bit exp_rd, exp_fs;
        m = edges;
        n = (m >= D + 2) ? ((m - 2) / D - 1) : -1;
        if (n < 0) begin
            check("pins", {vga_red, vga_grn, vga_blu, vga_hsync, vga_vsync}, {8'h00, 1'b1, 1'b1});
        end else begin
            h = n % HT;
            v = (n / HT) % VT;
            rgb = (in_active(h, v) && en_log[(n + 1) * D]) ? mem[addr_of(h, v)] : 8'h00;
            check("pins", {vga_red, vga_grn, vga_blu, vga_hsync, vga_vsync},
                  {rgb, !(h >= HS0 && h < HS1), !(v >= VS0 && v < VS1)});
        end
        if (m == 0) exp_addr = '0;
        exp_rd = 1'b0;
        if (m >= D && (m % D) == 0) begin
            n = m / D - 1;
            h = n % HT;
            v = (n / HT) % VT;
            if (in_active(h, v) && en_log[m]) begin
                exp_rd   = 1'b1;
                exp_addr = 13'(addr_of(h, v));
            end
        end
        t = m + 1;
        exp_fs = 1'b0;
        if ((t % D) == 0) begin
            n = t / D - 1;
            exp_fs = ((n % HT) == 0) && (((n / HT) % VT) == VA);
        end
        check("fetch", {fb_rd, fb_addr, frame_start}, {exp_rd, exp_addr, exp_fs});
    endtask

    task automatic step();
        @(negedge sys_clk);
        bg_check();
    endtask

    task automatic wait_edge(input int target);
        for (int k = 0; k < 60000 && edges < target; k++) step();
        check("reach_edge", edges, target);
    endtask

    initial begin
        int e, fs_cnt;
        vec[0]  = '{0,   0,  1'b1, 8'hE3, 13'd0,    1'b1, 1'b0, 3'd7, 3'd0, 2'd3, 1'b1, 1'b1};
        vec[1]  = '{15,  8,  1'b1, 8'h1C, 13'd263,  1'b1, 1'b0, 3'd0, 3'd7, 2'd0, 1'b1, 1'b1};
        vec[2]  = '{127, 8,  1'b1, 8'h5A, 13'd319,  1'b1, 1'b0, 3'd2, 3'd6, 2'd2, 1'b1, 1'b1};
        vec[3]  = '{130, 8,  1'b1, 8'h00, 13'd319,  1'b0, 1'b0, 3'd0, 3'd0, 2'd0, 1'b1, 1'b1};
        vec[4]  = '{140, 8,  1'b1, 8'h00, 13'd319,  1'b0, 1'b0, 3'd0, 3'd0, 2'd0, 1'b0, 1'b1};
        vec[5]  = '{10,  9,  1'b0, 8'h00, 13'd319,  1'b0, 1'b0, 3'd0, 3'd0, 2'd0, 1'b1, 1'b1};
        vec[6]  = '{13,  9,  1'b1, 8'h81, 13'd262,  1'b1, 1'b0, 3'd4, 3'd0, 2'd1, 1'b1, 1'b1};
        vec[7]  = '{127, 31, 1'b1, 8'hFF, 13'd1023, 1'b1, 1'b0, 3'd7, 3'd7, 2'd3, 1'b1, 1'b1};
        vec[8]  = '{0,   32, 1'b1, 8'h00, 13'd1023, 1'b0, 1'b1, 3'd0, 3'd0, 2'd0, 1'b1, 1'b1};
        vec[9]  = '{5,   34, 1'b1, 8'h00, 13'd1023, 1'b0, 1'b0, 3'd0, 3'd0, 2'd0, 1'b1, 1'b0};
        vec[10] = '{140, 36, 1'b1, 8'h00, 13'd1023, 1'b0, 1'b0, 3'd0, 3'd0, 2'd0, 1'b0, 1'b0};
        vec[11] = '{0,   37, 1'b1, 8'h00, 13'd1023, 1'b0, 1'b0, 3'd0, 3'd0, 2'd0, 1'b1, 1'b1};

        for (int i = 0; i < 1024; i++) mem[i] = 8'($urandom);
        for (int i = 0; i < NV; i++) if (vec[i].rd) mem[vec[i].addr] = vec[i].px;

        sys_rst = 1'b1;
        enable  = 1'b0;
        #1 sys_rst = 1'b0;
        repeat (10) step();
        check("reset_vals", {vga_red, vga_grn, vga_blu, vga_hsync, vga_vsync, fb_rd, fb_addr, frame_start},
              {8'h00, 1'b1, 1'b1, 1'b0, 13'd0, 1'b0});

        enable  = 1'b1;
        sys_rst = 1'b1;
        wait_edge(D - 1);
        check("pre_tick_rd", fb_rd, 1'b0);

        for (int i = 0; i < NV; i++) begin
            e = ((vec[i].v * HT + vec[i].h) + 1) * D;
            enable = vec[i].en;
            wait_edge(e - 1);
            check($sformatf("tbl%0d_fs", i), frame_start, vec[i].fs);
            wait_edge(e);
            check($sformatf("tbl%0d_rd", i), fb_rd, vec[i].rd);
            check($sformatf("tbl%0d_addr", i), fb_addr, vec[i].addr);
            wait_edge(e + 2);
            check($sformatf("tbl%0d_pins", i), {vga_red, vga_grn, vga_blu, vga_hsync, vga_vsync},
                  {vec[i].r, vec[i].g, vec[i].b, vec[i].hs, vec[i].vs});
        end

        // Random enable traffic up to line 20 of the second frame.
        for (int k = 0; k < 30000 && edges < (HT * VT + 20 * HT + 1) * D; k++) begin
            step();
            if ($urandom_range(0, 99) < 2) enable = !enable;
        end
        enable = 1'b1;
        for (int k = 0; k < 400 && fb_rd !== 1'b1; k++) step();
        check("rd_before_rst", fb_rd, 1'b1);
        #1 sys_rst = 1'b0;
        #1 check("async_rst", {vga_red, vga_grn, vga_blu, vga_hsync, vga_vsync, fb_rd, fb_addr, frame_start},
                 {8'h00, 1'b1, 1'b1, 1'b0, 13'd0, 1'b0});
        repeat (5) step();

        for (int i = 0; i < 1024; i++) mem[i] = 8'hFF;
        enable  = 1'b1;
        sys_rst = 1'b1;
        wait_edge(D + 1);
        check("no_stale", {vga_red, vga_grn, vga_blu}, 8'h00);
        wait_edge(D + 2);
        check("first_px", {vga_red, vga_grn, vga_blu}, 8'hFF);

        fs_cnt = 0;
        for (int k = 0; k < 20000 && edges < HT * VT * D + 10; k++) begin
            step();
            if (frame_start === 1'b1) fs_cnt++;
            if ($urandom_range(0, 99) < 2) enable = !enable;
        end
        check("fs_per_frame", fs_cnt, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/vga_fb_ctrl.md
Name: vga_fb_ctrl

Overview:
- VGA scan-out stage that drives the system's vga_red/vga_grn/vga_blu/vga_hsync/vga_vsync pins.
- Generates 640x480@60 timing from sys_clk using a pixel-enable divider.
- Fetches RGB332 pixels from an 80x60 byte framebuffer, which the d8_top side fills. Each framebuffer byte is upscaled to an 8x8 screen block.
- Emits a vblank pulse the CPU side uses to pace framebuffer updates.

Parameters:
- CLK_DIV, 4, sys_clk cycles per pixel; must be >= 2; 100 MHz / 4 = 25 MHz pixel rate.
- H_ACTIVE, 640, visible pixels per line.
- H_FP, 16, horizontal front porch in pixels.
- H_SYNC, 96, hsync pulse width in pixels.
- H_BP, 48, horizontal back porch in pixels.
- V_ACTIVE, 480, visible lines.
- V_FP, 10, vertical front porch in lines.
- V_SYNC, 2, vsync pulse width in lines.
- V_BP, 33, vertical back porch in lines.
- SCALE_SHIFT, 3, log2 of the upscale factor; FB_W = H_ACTIVE>>SCALE_SHIFT = 80, FB_H = 60.

Ports:
- sys_clk  in  1  system clock.
- sys_rst  in  1  reset; asynchronous, active-low.
- enable  in  1  1 = display framebuffer, 0 = force black output.
- fb_rd  out  1  framebuffer read strobe, one sys_clk cycle wide.
- fb_addr  out  13  framebuffer byte address, 0..4799.
- fb_data  in  8  RGB332 byte; valid the sys_clk cycle after fb_rd.
- vga_red  out  3  fb_data[7:5].
- vga_grn  out  3  fb_data[4:2].
- vga_blu  out  2  fb_data[1:0].
- vga_hsync  out  1  active-low horizontal sync.
- vga_vsync  out  1  active-low vertical sync.
- frame_start  out  1  one-cycle pulse at start of vblank.

Behaviour:
- Reset (sys_rst low, asynchronous): the following are cleared to their reset values.
  - div, h and v counters = 0.
  - vga_hsync = vga_vsync = 1.
  - RGB outputs = 0.
  - fb_rd = 0, fb_addr = 0, frame_start = 0.
  - Asserting reset mid-frame aborts the frame immediately.
  - After release, timing restarts at h=0, v=0 on the first pixel tick.
- Divider: div counts 0..CLK_DIV-1. Pixel tick = (div == CLK_DIV-1).
- h counter: 0..H_TOTAL-1 (H_TOTAL = 800), advances on each tick.
- v counter: 0..V_TOTAL-1 (V_TOTAL = 525), advances when h wraps from 799 to 0. It wraps from 524 to 0.
- Stage 0, the tick cycle at (h,v):
  - active = (h < H_ACTIVE) && (v < V_ACTIVE).
  - If active && enable: fb_rd = 1 next cycle, fb_addr = (v>>SCALE_SHIFT)*FB_W + (h>>SCALE_SHIFT).
  - Otherwise fb_rd = 0 and fb_addr holds its value.
  - The product is computed in at least 13 bits; no truncation.
- Stage 1, the fb_rd cycle: fb_data is sampled on the next edge.
- Stage 2 output register:
  - RGB = sampled fb_data if the pipelined active&&enable is set, else 0.
  - hsync = !(h in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC)), i.e. low for h in 656..751.
  - vsync = !(v in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC)), i.e. low for v in 490..491.
  - Both syncs are delayed through the same pipeline as RGB, so all five VGA outputs change on the same edge.
  - Fixed latency: 3 sys_clk from the tick to the pins.
  - Outputs hold between updates.
- frame_start: 1-cycle pulse on the tick where h==0 and v==V_ACTIVE. It is not delayed and occurs regardless of enable.
- enable:
  - Sampled at each tick.
  - Timing and syncs run regardless of enable.
  - Toggling enable mid-line takes effect from the next pixel; there are no partial-pixel glitches.
- fb_rd is never asserted during blanking. Exactly 640*480 reads occur per enabled frame, with each address read 64 times.
- A mid-frame sys_rst pulse while fb_rd is high: fb_rd drops asynchronously; no stale pixel is output after release.

Decomposition:
- Shared include vga_defs.vh holds:
  - the default timing constants;
  - derived H_TOTAL, V_TOTAL, FB_W, FB_H;
  - FB_AW = 13.
- One sub-module, vga_timing: divider, h/v counters, raw sync/active flags, tick and frame_start.
- vga_fb_ctrl adds the address computation, the fetch pipeline and the output registers.

Test Plan:
- Reset values: hold sys_rst low 10 cycles -> hsync=vsync=1, RGB=0, fb_rd=0, fb_addr=0, frame_start=0. After release, first tick at cycle 3.
- Horizontal timing: hsync period = 3200 sys_clk, low width = 384 sys_clk, falling edge 2624 cycles after the h=0 output.
- Vertical timing: vsync period = 525 lines (1,680,000 sys_clk), low for 2 lines. frame_start pulses once per frame at (0,480).
- Address mapping:
  - pixel (0,0) -> fb_addr 0;
  - pixel (15,8) -> 81;
  - pixel (639,479) -> 4799;
  - no fb_rd at h=640 or at v=480.
- Data path:
  - fb model returns 0xE3 -> red=7, grn=0, blu=3 on pins 3 cycles after the tick.
  - fb model returns 0xFF at all addresses -> pins stay black throughout blanking.
- Enable and reset:
  - enable=0 -> RGB=0 with syncs unchanged.
  - sys_rst low at v=200 -> immediate reset values; restart at h=0, v=0 with no stale pixel.
